// File: rtl/meter_button_conditioner.sv
// meter_button_conditioner
// Conditions six raw pushbuttons (add1..add4, rst1, rst2) into clean
// single-cycle command pulses for the parking meter FSM: 2-flop
// synchronizer, counter debounce, rising-edge press detection, fixed
// priority arbitration (rst1 > rst2 > add1 > add2 > add3 > add4) and a
// registered output stage.
// Optional feature macro: AUTO_REPEAT_EN (auto-repeat on held add buttons).
//
// Internal vectors use the btn_level ordering throughout:
//   bit 5 = rst1, bit 4 = rst2, bit 3 = add1, bit 2 = add2,
//   bit 1 = add3, bit 0 = add4.
module meter_button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 5,
    parameter int HOLD_CYCLES     = 100,
    parameter int REPEAT_CYCLES   = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       add1_raw,
    input  logic       add2_raw,
    input  logic       add3_raw,
    input  logic       add4_raw,
    input  logic       rst1_raw,
    input  logic       rst2_raw,
    output logic       add1,
    output logic       add2,
    output logic       add3,
    output logic       add4,
    output logic       rst1,
    output logic       rst2,
    output logic [5:0] btn_level,
    output logic       collision
);

    // Reject parameter values the 4-bit debounce counter and the repeat
    // counters cannot represent.
    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 15 ||
        HOLD_CYCLES < 1 || HOLD_CYCLES > 65535 ||
        REPEAT_CYCLES < 1 || REPEAT_CYCLES > 65535) begin : g_bad_params
        $error("meter_button_conditioner: parameter out of range");
    end

    localparam logic [3:0] DB_LAST = 4'(DEBOUNCE_CYCLES - 1);

    logic [5:0] raw_vec;
    logic [5:0] sync1;
    logic [5:0] sync2;
    logic [5:0] level;
    logic [5:0] level_q;
    logic [3:0] db_cnt [6];
    logic [5:0] press_ev;
    logic [5:0] ev;
    logic [5:0] grant;
    logic       drop;
    logic [5:0] cmd_q;

    assign raw_vec = {rst1_raw, rst2_raw, add1_raw, add2_raw, add3_raw, add4_raw};

    // Two-flop synchronizer for the asynchronous button levels.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw_vec;
            sync2 <= sync1;
        end
    end

    // Debounce: accept a new level only after DEBOUNCE_CYCLES consecutive
    // samples that disagree with the current stable level.
    always_ff @(posedge clk) begin
        if (rst) begin
            level <= '0;
            for (int i = 0; i < 6; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 6; i++) begin
                if (sync2[i] == level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    level[i]  <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 4'd1;
                end
            end
        end
    end

    // Delayed copy of the stable levels used to spot 0->1 transitions.
    always_ff @(posedge clk) begin
        if (rst) level_q <= '0;
        else     level_q <= level;
    end

    assign press_ev = level & ~level_q;

`ifdef AUTO_REPEAT_EN
    localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES);
    localparam logic [15:0] REP_LAST  = 16'(REPEAT_CYCLES);

    // rep_cnt counts cycles since the last emitted press/repeat; rep_phase
    // selects between the initial hold delay and the repeat spacing.
    logic [15:0] rep_cnt [4];
    logic [3:0]  rep_phase;
    logic [3:0]  rep_ev;

    // A repeat event fires when a still-held add button reaches its target.
    always_comb begin
        rep_ev = '0;
        for (int i = 0; i < 4; i++) begin
            rep_ev[i] = level[i] && (rep_cnt[i] == (rep_phase[i] ? REP_LAST : HOLD_LAST));
        end
    end

    // Repeat counters for the add buttons; release clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            rep_phase <= '0;
            for (int i = 0; i < 4; i++) rep_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (!level[i]) begin
                    rep_cnt[i]   <= '0;
                    rep_phase[i] <= 1'b0;
                end else if (press_ev[i]) begin
                    rep_cnt[i]   <= 16'd1;
                    rep_phase[i] <= 1'b0;
                end else if (rep_ev[i]) begin
                    rep_cnt[i]   <= 16'd1;
                    rep_phase[i] <= 1'b1;
                end else begin
                    rep_cnt[i]   <= rep_cnt[i] + 16'd1;
                end
            end
        end
    end

    assign ev = press_ev | {2'b00, rep_ev};
`else
    assign ev = press_ev;
`endif

    // Fixed-priority arbitration; anything not granted this cycle is dropped.
    always_comb begin
        grant = '0;
        if      (ev[5]) grant = 6'b100000;
        else if (ev[4]) grant = 6'b010000;
        else if (ev[3]) grant = 6'b001000;
        else if (ev[2]) grant = 6'b000100;
        else if (ev[1]) grant = 6'b000010;
        else if (ev[0]) grant = 6'b000001;
        drop = |(ev & ~grant);
    end

    // Registered command pulses and collision flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_q     <= '0;
            collision <= 1'b0;
        end else begin
            cmd_q     <= grant;
            collision <= drop;
        end
    end

    assign {rst1, rst2, add1, add2, add3, add4} = cmd_q;
    assign btn_level = level;

endmodule

// File: tb/tb_meter_button_conditioner.sv
// Bench for meter_button_conditioner: a vector table for the directed
// latency/reset cases, hand-written multi-cycle sequences, and a random
// phase checked cycle by cycle against a window-based reference model.
module tb_meter_button_conditioner;

    localparam int D    = 5;
    localparam int HOLD = 100;
    localparam int REP  = 50;
    localparam int MAXE = 20000;

    logic clk = 1'b0;
    logic rst;
    logic add1_raw, add2_raw, add3_raw, add4_raw, rst1_raw, rst2_raw;
    logic add1, add2, add3, add4, rst1, rst2;
    logic [5:0] btn_level;
    logic collision;
    logic [5:0] dut_cmd;

    always #5 clk = ~clk;

    meter_button_conditioner dut (
        .clk(clk), .rst(rst),
        .add1_raw(add1_raw), .add2_raw(add2_raw), .add3_raw(add3_raw),
        .add4_raw(add4_raw), .rst1_raw(rst1_raw), .rst2_raw(rst2_raw),
        .add1(add1), .add2(add2), .add3(add3), .add4(add4),
        .rst1(rst1), .rst2(rst2),
        .btn_level(btn_level), .collision(collision)
    );

    assign dut_cmd = {rst1, rst2, add1, add2, add3, add4};

    int total = 0;
    int bad   = 0;

    // Stimulus history, indexed by clock edge number.
    logic [5:0] raw_h [MAXE];
    bit         rst_h [MAXE];
    int         e_n = 0;

    // Reference model state (values visible after the latest edge).
    logic [5:0] m_level = '0;
    logic [5:0] m_ev    = '0;
    logic [5:0] m_cmd   = '0;
    logic       m_col   = 1'b0;
    int         rise_edge [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s edge=%0d got=%0h want=%0h", name, e_n - 1, act, exp);
        end
    endtask

    // Synchronized value seen by the debouncer at edge m: the raw level
    // from two edges earlier, or 0 if a reset edge cleared the pipeline.
    function automatic logic [5:0] seen(input int m);
        if (m < 2) return '0;
        if (rst_h[m-1] || rst_h[m-2]) return '0;
        return raw_h[m-2];
    endfunction

    function automatic logic [5:0] highest(input logic [5:0] v);
        for (int b = 5; b >= 0; b--) begin
            if (v[b]) return 6'(1 << b);
        end
        return '0;
    endfunction

    // Model: a level flips at edge m when the last D seen samples, all
    // after the most recent reset, disagree with it. Events are rises
    // (plus repeats when enabled); outputs appear one edge later.
    task automatic model_step(input int m);
        logic [5:0] nl;
        logic [5:0] rises;
        logic [5:0] rep;
        bit ok;
        int d;
        if (rst_h[m]) begin
            m_level = '0; m_ev = '0; m_cmd = '0; m_col = 1'b0;
            for (int b = 0; b < 6; b++) rise_edge[b] = -1;
            return;
        end
        m_cmd = highest(m_ev);
        m_col = ($countones(m_ev) > 1);
        nl = m_level;
        for (int b = 0; b < 6; b++) begin
            ok = 1'b1;
            for (int j = 0; j < D; j++) begin
                if (m - j < 0 || rst_h[m-j]) ok = 1'b0;
                else if (seen(m - j)[b] == m_level[b]) ok = 1'b0;
            end
            if (ok) nl[b] = ~m_level[b];
        end
        rises = nl & ~m_level;
        rep = '0;
`ifdef AUTO_REPEAT_EN
        for (int b = 0; b < 4; b++) begin
            if (rises[b]) rise_edge[b] = m;
            else if (!nl[b]) rise_edge[b] = -1;
            else if (rise_edge[b] >= 0) begin
                d = m - rise_edge[b];
                if (d == HOLD || (d > HOLD && (d - HOLD) % REP == 0)) rep[b] = 1'b1;
            end
        end
`else
        d = 0;
`endif
        m_ev = rises | rep;
        m_level = nl;
    endtask

    // One clock: drive at negedge, model the edge, compare 1 time unit after.
    task automatic tick(input logic [5:0] r, input logic rv);
        @(negedge clk);
        {rst1_raw, rst2_raw, add1_raw, add2_raw, add3_raw, add4_raw} = r;
        rst = rv;
        if (e_n >= MAXE) begin
            $display("FAIL edge_budget edge=%0d got=%0d want<%0d", e_n, e_n, MAXE);
            $fatal(1, "edge budget exceeded");
        end
        raw_h[e_n] = r;
        rst_h[e_n] = rv;
        @(posedge clk);
        model_step(e_n);
        e_n++;
        #1;
        check("model_cmd", 32'(dut_cmd), 32'(m_cmd));
        check("model_level", 32'(btn_level), 32'(m_level));
        check("model_collision", 32'(collision), 32'(m_col));
        check("onehot", 32'($countones(dut_cmd) > 1), 32'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(6'b000000, 1'b0);
    endtask

    typedef struct {
        logic [5:0] raw;
        logic       rst;
        logic [5:0] cmd;
        logic [5:0] lvl;
    } vec_t;

    vec_t tbl [32];

    initial begin
        int cnt_a, cnt_b, cnt_c, rel;
        logic [5:0] seq2 [5];
        int dur [6];
        logic [5:0] rlev;
        logic rrst;

        for (int b = 0; b < 6; b++) rise_edge[b] = -1;
        {rst1_raw, rst2_raw, add1_raw, add2_raw, add3_raw, add4_raw} = '0;
        rst = 1'b1;

        // Vector table: add2 held (rows 0-9), released (10-17), then add4
        // held with a one-cycle reset at its relative edge 4 (rows 18-31).
        for (int k = 0; k < 32; k++) begin
            if (k < 10) begin
                tbl[k] = '{6'b000100, 1'b0, (k == 7) ? 6'b000100 : 6'b0,
                           (k >= 6) ? 6'b000100 : 6'b0};
            end else if (k < 18) begin
                tbl[k] = '{6'b000000, 1'b0, 6'b0, (k <= 15) ? 6'b000100 : 6'b0};
            end else begin
                tbl[k] = '{6'b000001, (k - 18 == 4), (k - 18 == 12) ? 6'b000001 : 6'b0,
                           (k - 18 >= 11) ? 6'b000001 : 6'b0};
            end
        end

        // Reset state.
        for (int i = 0; i < 3; i++) tick(6'b000000, 1'b1);
        check("reset_cmd", 32'(dut_cmd), 32'd0);
        check("reset_level", 32'(btn_level), 32'd0);
        check("reset_collision", 32'(collision), 32'd0);
        idle(10);

        for (int k = 0; k < 32; k++) begin
            tick(tbl[k].raw, tbl[k].rst);
            check("tbl_cmd", 32'(dut_cmd), 32'(tbl[k].cmd));
            check("tbl_level", 32'(btn_level), 32'(tbl[k].lvl));
            check("tbl_collision", 32'(collision), 32'd0);
        end
        idle(10);

        // add1 bounces 1,0,1,1,0 then stays high: one pulse, 12 edges in.
        seq2 = '{6'b001000, 6'b000000, 6'b001000, 6'b001000, 6'b000000};
        cnt_a = 0; rel = -1;
        for (int k = 0; k < 20; k++) begin
            tick((k < 5) ? seq2[k] : 6'b001000, 1'b0);
            if (add1) begin cnt_a++; rel = k; end
        end
        check("bounce_pulses", 32'(cnt_a), 32'd1);
        check("bounce_edge", 32'(rel), 32'd12);
        idle(10);

        // 4-sample glitch: ignored entirely.
        cnt_a = 0; cnt_b = 0;
        for (int k = 0; k < 16; k++) begin
            tick((k < 4) ? 6'b001000 : 6'b000000, 1'b0);
            if (add1) cnt_a++;
            if (btn_level[3]) cnt_b++;
        end
        check("glitch_pulses", 32'(cnt_a), 32'd0);
        check("glitch_level", 32'(cnt_b), 32'd0);

        // rst2 and add3 rise together: rst2 wins, collision flagged.
        cnt_a = 0; cnt_b = 0; cnt_c = 0;
        for (int k = 0; k < 12; k++) begin
            tick(6'b010010, 1'b0);
            if (k == 7) begin
                check("simul_cmd", 32'(dut_cmd), 32'b010000);
                check("simul_collision", 32'(collision), 32'd1);
            end
            if (rst2) cnt_a++;
            if (add3) cnt_b++;
            if (collision) cnt_c++;
        end
        check("simul_rst2_count", 32'(cnt_a), 32'd1);
        check("simul_add3_count", 32'(cnt_b), 32'd0);
        check("simul_collision_count", 32'(cnt_c), 32'd1);
        idle(10);

        // Long holds: add1 repeats only with the feature built in; rst1 never.
        cnt_a = 0;
        for (int k = 0; k < 310; k++) begin
            tick((k < 300) ? 6'b001000 : 6'b000000, 1'b0);
            if (add1) cnt_a++;
        end
`ifdef AUTO_REPEAT_EN
        check("hold_add1_pulses", 32'(cnt_a), 32'd5);
`else
        check("hold_add1_pulses", 32'(cnt_a), 32'd1);
`endif
        cnt_a = 0;
        for (int k = 0; k < 310; k++) begin
            tick((k < 300) ? 6'b100000 : 6'b000000, 1'b0);
            if (rst1) cnt_a++;
        end
        check("hold_rst1_pulses", 32'(cnt_a), 32'd1);
        idle(5);

        // Random bouncy buttons with occasional resets, model-checked.
        rlev = '0;
        for (int b = 0; b < 6; b++) dur[b] = 0;
        for (int k = 0; k < 3000; k++) begin
            for (int b = 0; b < 6; b++) begin
                if (dur[b] == 0) begin
                    rlev[b] = $urandom_range(0, 1);
                    dur[b] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4)
                                                         : $urandom_range(5, 40);
                end
                dur[b]--;
            end
            rrst = ($urandom_range(0, 299) == 0);
            tick(rlev, rrst);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
